// File: rtl/accel_axis_scheduler_pkg.sv
// Shared parameter header for the accelerometer axis scheduler and the SPI
// reader that it drives.
//   - FSM state encodings. The reader decodes these, so the values are fixed.
//   - Axis codes placed on oDIMENSION.
//   - pick_axis(): finds the lowest enabled axis at or above a start code.
package accel_axis_scheduler_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SELECT  = 3'd1;
  localparam logic [2:0] ST_DISCARD = 3'd2;
  localparam logic [2:0] ST_CAPTURE = 3'd3;
  localparam logic [2:0] ST_PUBLISH = 3'd4;

  localparam logic [1:0] AXIS_X = 2'd0;
  localparam logic [1:0] AXIS_Y = 2'd1;
  localparam logic [1:0] AXIS_Z = 2'd2;

  typedef struct packed {
    logic       found;
    logic [1:0] axis;
  } axis_pick_t;

  // Lowest axis i with mask[i] set and i >= start. A start of 3 finds nothing,
  // which is how "no further axis after Z" falls out of the search.
  function automatic axis_pick_t pick_axis(input logic [2:0] mask,
                                           input logic [1:0] start);
    axis_pick_t r;
    r.found = 1'b0;
    r.axis  = AXIS_X;
    // Scan downwards so that the lowest qualifying axis is the last one written.
    for (int i = 2; i >= 0; i--) begin
      if (mask[i] && (2'(i) >= start)) begin
        r.found = 1'b1;
        r.axis  = 2'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/accel_axis_scheduler_timeout.sv
// axis_timeout_counter: a loadable down-counter with a terminal-count flag.
//   clk  : clock
//   rstn : synchronous active-low reset (clears the count)
//   load : reload to TIMEOUT_CYCLES-1 (takes priority over counting)
//   run  : count down while high; tc is only reported while running
//   tc   : high during the TIMEOUT_CYCLES-th running cycle after a load
// TIMEOUT_CYCLES must be at least 1.
module axis_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic rstn,
  input  logic load,
  input  logic run,
  output logic tc
);

  localparam int unsigned     CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0]   LOAD_VAL = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (run && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Not gated by load: a strobe arriving in the same cycle is resolved by the
  // scheduler, which gives the strobe priority.
  assign tc = run && (cnt_q == '0);

endmodule

// File: rtl/accel_axis_scheduler.sv
// accel_axis_scheduler: steps an SPI accelerometer reader through the enabled
// axes (X, Y, Z), drops the first DISCARD_CNT samples after each axis switch,
// captures one word per axis, and publishes a frame over a valid/ready pair.
//
// Handshake: oVALID rises with a new frame and, together with oX/oY/oZ, holds
// steady until the cycle in which oVALID && iREADY; that cycle is the
// transfer. iREADY has no effect while oVALID is low.
//
// Ports
//   iSPI_CLK, iRSTN        clock, synchronous active-low reset
//   iENABLE                keep running frames; low = idle after the current one
//   iAXIS_MASK[2:0]        axes to sample (bit0 X, bit1 Y, bit2 Z)
//   iDATA_H/iDATA_L        word from the reader, qualified by iSAMPLE_STB
//   oDIMENSION[1:0]        axis select to the reader
//   oX/oY/oZ, oVALID       published frame; iREADY consumer accept
//   oTIMEOUT, iCLR_TIMEOUT sticky axis-timeout flag and its clear
//   oBUSY                  not idle
//   oSTATE_DBG[2:0]        current FSM state (package encodings)
module accel_axis_scheduler #(
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned DISCARD_CNT    = 1
) (
  input  logic        iSPI_CLK,
  input  logic        iRSTN,
  input  logic        iENABLE,
  input  logic [2:0]  iAXIS_MASK,
  input  logic [7:0]  iDATA_L,
  input  logic [7:0]  iDATA_H,
  input  logic        iSAMPLE_STB,
  output logic [1:0]  oDIMENSION,
  output logic [15:0] oX,
  output logic [15:0] oY,
  output logic [15:0] oZ,
  output logic        oVALID,
  input  logic        iREADY,
  output logic        oTIMEOUT,
  input  logic        iCLR_TIMEOUT,
  output logic        oBUSY,
  output logic [2:0]  oSTATE_DBG
);

  import accel_axis_scheduler_pkg::*;

  localparam logic [1:0] DISC_LAST = (DISCARD_CNT == 0) ? 2'd0 : 2'(DISCARD_CNT - 1);

  logic [2:0]        state_q, state_d;
  logic [1:0]        dim_q, dim_d;
  logic [2:0]        fmask_q, fmask_d;
  logic [1:0]        disc_q, disc_d;
  logic [2:0][15:0]  frame_q, frame_d;
  logic [2:0][15:0]  out_q, out_d;
  logic              valid_q, valid_d;
  logic              to_q, to_d;

  logic       cnt_load, cnt_run, cnt_tc;
  logic       to_set, advance;
  axis_pick_t pick_first, pick_next;

  axis_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk  (iSPI_CLK),
    .rstn (iRSTN),
    .load (cnt_load),
    .run  (cnt_run),
    .tc   (cnt_tc)
  );

  always_comb begin
    state_d  = state_q;
    dim_d    = dim_q;
    fmask_d  = fmask_q;
    disc_d   = disc_q;
    frame_d  = frame_q;
    out_d    = out_q;
    valid_d  = valid_q;
    cnt_load = 1'b0;
    cnt_run  = 1'b0;
    to_set   = 1'b0;
    advance  = 1'b0;

    // First axis of a new frame comes from the live mask; later axes come from
    // the mask latched at frame start, so mid-frame mask changes are ignored.
    pick_first = pick_axis(iAXIS_MASK, AXIS_X);
    pick_next  = pick_axis(fmask_q, dim_q + 2'd1);

    case (state_q)
      ST_IDLE: begin
        if (iENABLE && pick_first.found) begin
          fmask_d = iAXIS_MASK;
          dim_d   = pick_first.axis;
          state_d = ST_SELECT;
        end
      end

      ST_SELECT: begin
        cnt_load = 1'b1;
        disc_d   = 2'd0;
        state_d  = (DISCARD_CNT == 0) ? ST_CAPTURE : ST_DISCARD;
      end

      ST_DISCARD: begin
        cnt_run = 1'b1;
        if (iSAMPLE_STB) begin
          cnt_load = 1'b1;
          if (disc_q == DISC_LAST) begin
            state_d = ST_CAPTURE;
          end else begin
            disc_d = disc_q + 2'd1;
          end
        end else if (cnt_tc) begin
          to_set  = 1'b1;
          advance = 1'b1;
        end
      end

      ST_CAPTURE: begin
        cnt_run = 1'b1;
        if (iSAMPLE_STB) begin
          cnt_load          = 1'b1;
          frame_d[dim_q]    = {iDATA_H, iDATA_L};
          advance           = 1'b1;
        end else if (cnt_tc) begin
          to_set  = 1'b1;
          advance = 1'b1;
        end
      end

      ST_PUBLISH: begin
        if (iREADY) begin
          valid_d = 1'b0;
          if (iENABLE && pick_first.found) begin
            fmask_d = iAXIS_MASK;
            dim_d   = pick_first.axis;
            state_d = ST_SELECT;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Leave the current axis (captured or timed out): next enabled axis, or
    // publish. Outputs load from frame_d so a capture on this same edge is
    // included; unmasked axes keep their previous published value.
    if (advance) begin
      if (pick_next.found) begin
        dim_d   = pick_next.axis;
        state_d = ST_SELECT;
      end else begin
        state_d = ST_PUBLISH;
        valid_d = 1'b1;
        for (int i = 0; i < 3; i++) begin
          if (fmask_q[i]) begin
            out_d[i] = frame_d[i];
          end
        end
      end
    end

    // A timeout raised this cycle beats a simultaneous clear.
    if (to_set) begin
      to_d = 1'b1;
    end else if (iCLR_TIMEOUT) begin
      to_d = 1'b0;
    end else begin
      to_d = to_q;
    end
  end

  always_ff @(posedge iSPI_CLK) begin
    if (!iRSTN) begin
      state_q <= ST_IDLE;
      dim_q   <= AXIS_X;
      fmask_q <= 3'b000;
      disc_q  <= 2'd0;
      frame_q <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dim_q   <= dim_d;
      fmask_q <= fmask_d;
      disc_q  <= disc_d;
      frame_q <= frame_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      to_q    <= to_d;
    end
  end

  assign oDIMENSION = dim_q;
  assign oX         = out_q[0];
  assign oY         = out_q[1];
  assign oZ         = out_q[2];
  assign oVALID     = valid_q;
  assign oTIMEOUT   = to_q;
  assign oBUSY      = (state_q != ST_IDLE);
  assign oSTATE_DBG = state_q;

endmodule
